// File: rtl/rs_pkg.sv
// Shared GF(2^8) arithmetic, generator construction and FSM state type
// for the frame-level Reed-Solomon encoder.
package rs_pkg;

  localparam logic [8:0] GF_POLY  = 9'h11D;
  localparam logic [7:0] GF_ALPHA = 8'h02;

  typedef enum logic [1:0] {IDLE, MSG, DONE} state_t;

  // Shift-and-add multiply in GF(2^8), reducing by GF_POLY whenever the
  // running multiplicand overflows bit 7.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ GF_POLY[7:0]) : (aa << 1);
    end
    return p;
  endfunction

  // Monic generator prod (x + alpha^i), i = 0..npar-1.
  // Coefficient of x^j sits in bits [8*j +: 8]; the leading 1 is at j = npar.
  function automatic logic [8*256-1:0] gen_poly(input int npar);
    logic [8*256-1:0] g;
    logic [7:0]       root;
    g       = '0;
    g[7:0]  = 8'h01;
    root    = 8'h01;
    for (int i = 0; i < npar; i++) begin
      for (int j = i + 1; j > 0; j--) begin
        g[8*j +: 8] = g[8*(j-1) +: 8] ^ gf_mul(root, g[8*j +: 8]);
      end
      g[7:0] = gf_mul(root, g[7:0]);
      root   = gf_mul(root, GF_ALPHA);
    end
    return g;
  endfunction

endpackage

// File: rtl/rs_lfsr.sv
// NPAR-stage parity LFSR: one message symbol per shift, constant GF
// multipliers taken from the elaboration-time generator polynomial.
module rs_lfsr
  import rs_pkg::*;
#(
  parameter int NPAR = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift,
  input  logic [7:0]        sym,
  output logic [8*NPAR-1:0] parity
);

  localparam logic [8*256-1:0] GEN = gen_poly(NPAR);

  logic [8*NPAR-1:0] r_q;
  logic [8*NPAR-1:0] r_d;
  logic [7:0]        fb;

  // Next register contents: feedback is the incoming symbol plus the top stage.
  always_comb begin
    r_d = r_q;
    fb  = sym ^ r_q[8*(NPAR-1) +: 8];
    if (shift) begin
      r_d[7:0] = gf_mul(fb, GEN[7:0]);
      for (int j = 1; j < NPAR; j++) begin
        r_d[8*j +: 8] = r_q[8*(j-1) +: 8] ^ gf_mul(fb, GEN[8*j +: 8]);
      end
    end
  end

  // Clear dominates shifting so a new frame or an abort always starts from zero.
  always_ff @(posedge clk) begin
    if (rst || clear) r_q <= '0;
    else              r_q <= r_d;
  end

  assign parity = r_q;

endmodule

// File: rtl/rs_enc_frame.sv
// Frame-level systematic RS encoder: captures a parallel message, feeds it
// byte-serially through rs_lfsr, then holds message + parity as one codeword
// under valid/ready back-pressure.
module rs_enc_frame
  import rs_pkg::*;
#(
  parameter int K    = 11,
  parameter int NPAR = 4,
  parameter int LW   = $clog2(K + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*K-1:0]        in_data,
  input  logic [LW-1:0]         in_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*(K+NPAR)-1:0] out_data,
  output logic [LW:0]           out_len,
  output logic                  out_len_err
);

  localparam int            N   = K + NPAR;
  localparam logic [LW-1:0] K_L = LW'(K);

  state_t            state_q, state_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [LW-1:0]     len_q, len_d;
  logic              err_q, err_d;
  logic [LW-1:0]     eff_len;
  logic [8*K-1:0]    buf_q;
  logic              capture;
  logic              shift;
  logic [7:0]        sym;
  logic [8*NPAR-1:0] parity;
  logic [8*N-1:0]    msg_ext;

  // A finished codeword can be swapped for the next frame in the same cycle.
  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign capture  = in_valid & in_ready;
  assign eff_len  = (in_len > K_L) ? K_L : in_len;
  assign shift    = (state_q == MSG);
  assign sym      = buf_q[8*int'(cnt_q) +: 8];

  // Next-state, counter and length bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    err_d   = err_q;
    case (state_q)
      MSG: begin
        cnt_d = cnt_q + LW'(1);
        if (cnt_q == len_q - LW'(1)) state_d = DONE;
      end
      default: begin
        if (capture) begin
          len_d   = eff_len;
          err_d   = (in_len > K_L);
          cnt_d   = '0;
          state_d = (eff_len != '0) ? MSG : DONE;
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Control registers; clr aborts any frame in flight exactly like rst.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  // Message buffer is data only; it is qualified by state everywhere it is used.
  always_ff @(posedge clk) begin
    if (capture) buf_q <= in_data;
  end

  rs_lfsr #(
    .NPAR(NPAR)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .clear (capture | clr),
    .shift (shift),
    .sym   (sym),
    .parity(parity)
  );

  assign msg_ext = {{(8*NPAR){1'b0}}, buf_q};

  // Codeword assembly: message, then parity highest stage first, then zeros.
  always_comb begin
    out_data = '0;
    if (state_q == DONE) begin
      for (int i = 0; i < N; i++) begin
        if (i < int'(len_q)) begin
          out_data[8*i +: 8] = msg_ext[8*i +: 8];
        end else if (i < int'(len_q) + NPAR) begin
          out_data[8*i +: 8] = parity[8*(NPAR-1-(i-int'(len_q))) +: 8];
        end
      end
    end
  end

  assign out_valid   = (state_q == DONE);
  assign out_len     = (state_q == DONE) ? ((LW+1)'(len_q) + (LW+1)'(NPAR)) : '0;
  assign out_len_err = (state_q == DONE) & err_q;

endmodule

// File: tb/tb_rs_enc_frame.sv
// Scoreboard bench for rs_enc_frame at K/NPAR = 11/4, 223/32 and 1/2.
module tb_rs_enc_frame;

  localparam int KA = 11,  NA = 4,  LA = $clog2(KA + 1);
  localparam int KB = 223, NB = 32, LB = $clog2(KB + 1);
  localparam int KC = 1,   NC = 2,  LC = $clog2(KC + 1);
  localparam int WMAX = 2040;

  typedef logic [WMAX-1:0] wide_t;
  typedef struct {
    wide_t data;
    int    len;
    bit    err;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_a = 1'b0, clr_b = 1'b0, clr_c = 1'b0;
  always #5 clk = ~clk;

  logic                   in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b1, out_len_err_a;
  logic [8*KA-1:0]        in_data_a = '0;
  logic [LA-1:0]          in_len_a = '0;
  logic [8*(KA+NA)-1:0]   out_data_a;
  logic [LA:0]            out_len_a;

  logic                   in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1, out_len_err_b;
  logic [8*KB-1:0]        in_data_b = '0;
  logic [LB-1:0]          in_len_b = '0;
  logic [8*(KB+NB)-1:0]   out_data_b;
  logic [LB:0]            out_len_b;

  logic                   in_valid_c = 1'b0, in_ready_c, out_valid_c, out_ready_c = 1'b1, out_len_err_c;
  logic [8*KC-1:0]        in_data_c = '0;
  logic [LC-1:0]          in_len_c = '0;
  logic [8*(KC+NC)-1:0]   out_data_c;
  logic [LC:0]            out_len_c;

  rs_enc_frame #(.K(KA), .NPAR(NA)) dut_a (
    .clk(clk), .rst(rst), .clr(clr_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .in_len(in_len_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_data(out_data_a), .out_len(out_len_a), .out_len_err(out_len_err_a));

  rs_enc_frame #(.K(KB), .NPAR(NB)) dut_b (
    .clk(clk), .rst(rst), .clr(clr_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .in_len(in_len_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_len(out_len_b), .out_len_err(out_len_err_b));

  rs_enc_frame #(.K(KC), .NPAR(NC)) dut_c (
    .clk(clk), .rst(rst), .clr(clr_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .in_data(in_data_c), .in_len(in_len_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
    .out_data(out_data_c), .out_len(out_len_c), .out_len_err(out_len_err_c));

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    while (x != 8'h00) begin
      if (x[0]) p = p ^ y;
      x = x >> 1;
      y = y[7] ? ((y << 1) ^ 8'h1D) : (y << 1);
    end
    return p;
  endfunction

  // Systematic codeword by polynomial long division of m(x)*x^npar by g(x).
  function automatic wide_t model_cw(input wide_t msg, input int len, input int npar);
    logic [7:0] g [0:32];
    logic [7:0] ng [0:32];
    logic [7:0] w [0:255];
    logic [7:0] root, c;
    wide_t cw;
    for (int k = 0; k <= 32; k++) g[k] = 8'h00;
    g[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < npar; i++) begin
      for (int k = 0; k <= 32; k++) ng[k] = m_mul(g[k], root);
      for (int k = 1; k <= 32; k++) ng[k] = ng[k] ^ g[k-1];
      for (int k = 0; k <= 32; k++) g[k] = ng[k];
      root = m_mul(root, 8'h02);
    end
    for (int k = 0; k < 256; k++) w[k] = 8'h00;
    for (int k = 0; k < len; k++) w[k] = msg[8*k +: 8];
    for (int i = 0; i < len; i++) begin
      c = w[i];
      for (int j = 1; j <= npar; j++) w[i+j] = w[i+j] ^ m_mul(c, g[npar-j]);
    end
    cw = '0;
    for (int k = 0; k < len; k++) cw[8*k +: 8] = msg[8*k +: 8];
    for (int k = len; k < len + npar; k++) cw[8*k +: 8] = w[k];
    return cw;
  endfunction

  function automatic wide_t rand_wide();
    wide_t w;
    for (int k = 0; k < 255; k++) w[8*k +: 8] = 8'($urandom);
    return w;
  endfunction

  // ---------------- comparison helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_cw(input string name, input wide_t act, input wide_t exp);
    int first;
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      first = -1;
      for (int k = 254; k >= 0; k--) if (act[8*k +: 8] !== exp[8*k +: 8]) first = k;
      $display("FAIL %s: byte %0d got %02h expected %02h", name, first,
               act[8*first +: 8], exp[8*first +: 8]);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!rst && out_valid_a && out_ready_a) begin
      if (q_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_unexpected: codeword out_len %0d with nothing expected", out_len_a);
      end else begin
        e = q_a.pop_front();
        chk_cw("a_data", wide_t'(out_data_a), e.data);
        chk("a_len", int'(out_len_a), e.len);
        chk("a_err", int'(out_len_err_a), int'(e.err));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!rst && out_valid_b && out_ready_b) begin
      if (q_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected: codeword out_len %0d with nothing expected", out_len_b);
      end else begin
        e = q_b.pop_front();
        chk_cw("b_data", wide_t'(out_data_b), e.data);
        chk("b_len", int'(out_len_b), e.len);
        chk("b_err", int'(out_len_err_b), int'(e.err));
      end
    end
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    if (!rst && out_valid_c && out_ready_c) begin
      if (q_c.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL c_unexpected: codeword out_len %0d with nothing expected", out_len_c);
      end else begin
        e = q_c.pop_front();
        chk_cw("c_data", wide_t'(out_data_c), e.data);
        chk("c_len", int'(out_len_c), e.len);
        chk("c_err", int'(out_len_err_c), int'(e.err));
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic send_a(input wide_t d, input int len);
    int t;
    @(posedge clk); #1;
    in_valid_a = 1'b1; in_data_a = d[8*KA-1:0]; in_len_a = LA'(len);
    t = 0;
    while (!in_ready_a && t < 500) begin @(posedge clk); #1; t++; end
    if (!in_ready_a) chk("a_send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    in_data_a  = 8*KA'(rand_wide());
  endtask

  task automatic send_b(input wide_t d, input int len);
    int t;
    @(posedge clk); #1;
    in_valid_b = 1'b1; in_data_b = d[8*KB-1:0]; in_len_b = LB'(len);
    t = 0;
    while (!in_ready_b && t < 1000) begin @(posedge clk); #1; t++; end
    if (!in_ready_b) chk("b_send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    in_data_b  = 8*KB'(rand_wide());
  endtask

  task automatic send_c(input wide_t d, input int len);
    int t;
    @(posedge clk); #1;
    in_valid_c = 1'b1; in_data_c = d[8*KC-1:0]; in_len_c = LC'(len);
    t = 0;
    while (!in_ready_c && t < 500) begin @(posedge clk); #1; t++; end
    if (!in_ready_c) chk("c_send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid_c = 1'b0;
    in_data_c  = 8*KC'(rand_wide());
  endtask

  task automatic drain_a(input int bound);
    int t = 0;
    while (q_a.size() != 0 && t < bound) begin @(negedge clk); t++; end
    chk("a_drain", q_a.size(), 0);
  endtask

  task automatic drain_b(input int bound);
    int t = 0;
    while (q_b.size() != 0 && t < bound) begin @(negedge clk); t++; end
    chk("b_drain", q_b.size(), 0);
  endtask

  task automatic drain_c(input int bound);
    int t = 0;
    while (q_c.size() != 0 && t < bound) begin @(negedge clk); t++; end
    chk("c_drain", q_c.size(), 0);
  endtask

  task automatic push_exp(input int which, input wide_t data, input int len, input bit err);
    exp_t e;
    e.data = data; e.len = len; e.err = err;
    case (which)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    wide_t d, x, ex_stall;
    int    seen, t, eff;
    int    lens_a[3] = '{11, 7, 3};
    int    lens_b[4] = '{223, 100, 230, 1};
    int    lens_c[3] = '{1, 0, 1};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready_a), 1);
    chk("rst_out_valid", int'(out_valid_a), 0);
    chk_cw("rst_out_data", wide_t'(out_data_a), '0);
    chk("rst_out_len", int'(out_len_a), 0);
    chk("rst_len_err", int'(out_len_err_a), 0);

    // single symbol 01 -> parity 0F 36 78 40
    x = '0; x[39:0] = 40'h40_78_36_0F_01;
    push_exp(0, x, 5, 1'b0);
    d = '0; d[7:0] = 8'h01;
    send_a(d, 1);
    drain_a(40);

    // leading zero symbol leaves the parity unchanged
    x = '0; x[47:0] = 48'h40_78_36_0F_01_00;
    push_exp(0, x, 6, 1'b0);
    d = '0; d[15:8] = 8'h01;
    send_a(d, 2);
    drain_a(40);

    // all-zero full frame
    push_exp(0, '0, 15, 1'b0);
    send_a('0, 11);
    drain_a(40);

    // back-pressure: symbol 03 -> parity 11 5A 88 C0, held while out_ready=0
    @(posedge clk); #1 out_ready_a = 1'b0;
    ex_stall = '0; ex_stall[39:0] = 40'hC0_88_5A_11_03;
    push_exp(0, ex_stall, 5, 1'b0);
    d = '0; d[7:0] = 8'h03;
    send_a(d, 1);
    t = 0;
    while (!out_valid_a && t < 20) begin @(negedge clk); t++; end
    chk("a_stall_valid", int'(out_valid_a), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_cw("a_stall_data", wide_t'(out_data_a), ex_stall);
      chk("a_stall_in_ready", int'(in_ready_a), 0);
    end
    // release and hand over symbol 02 -> parity 1E 6C F0 80 in the same cycle
    @(posedge clk); #1;
    x = '0; x[39:0] = 40'h80_F0_6C_1E_02;
    push_exp(0, x, 5, 1'b0);
    out_ready_a = 1'b1;
    in_valid_a  = 1'b1;
    in_data_a   = '0; in_data_a[7:0] = 8'h02;
    in_len_a    = LA'(1);
    #1 chk("a_b2b_in_ready", int'(in_ready_a), 1);
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    in_data_a  = 8*KA'(rand_wide());
    @(negedge clk);
    chk("a_b2b_gap", int'(out_valid_a), 0);
    @(negedge clk);
    chk("a_b2b_valid", int'(out_valid_a), 1);
    drain_a(40);

    // oversize length clamps to K and flags the error
    x = '0; x[87:80] = 8'h01; x[119:88] = 32'h40_78_36_0F;
    push_exp(0, x, 15, 1'b1);
    d = '0; d[87:80] = 8'h01;
    send_a(d, 13);
    drain_a(40);

    // empty frame: parity only, all zero
    push_exp(0, '0, 4, 1'b0);
    send_a(rand_wide(), 0);
    drain_a(40);

    // abort in the middle of the message
    send_a(rand_wide(), 11);
    repeat (4) begin @(posedge clk); #1; end
    clr_a = 1'b1;
    @(posedge clk); #1 clr_a = 1'b0;
    chk("a_abort_in_ready", int'(in_ready_a), 1);
    chk("a_abort_out_valid", int'(out_valid_a), 0);
    seen = 0;
    repeat (20) begin @(negedge clk); if (out_valid_a) seen = 1; end
    chk("a_abort_no_output", seen, 0);

    // random frames after the abort, checked against the division model
    for (int i = 0; i < 3; i++) begin
      d = rand_wide();
      push_exp(0, model_cw(d, lens_a[i], NA), lens_a[i] + NA, 1'b0);
      send_a(d, lens_a[i]);
      drain_a(60);
    end

    // wide code
    for (int i = 0; i < 4; i++) begin
      d   = rand_wide();
      eff = (lens_b[i] > KB) ? KB : lens_b[i];
      push_exp(1, model_cw(d, eff, NB), eff + NB, lens_b[i] > KB);
      send_b(d, lens_b[i]);
      drain_b(600);
    end

    // single-symbol code
    for (int i = 0; i < 3; i++) begin
      d = rand_wide();
      push_exp(2, model_cw(d, lens_c[i], NC), lens_c[i] + NC, 1'b0);
      send_c(d, lens_c[i]);
      drain_c(20);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
